// File: rtl/systolic_pkg.sv
// Shared types and helpers for the systolic matrix-multiply tile.
// sat_add backs the SYSTOLIC_SATURATE_EN build of systolic_pe.
package systolic_pkg;

    localparam int N_DEF      = 4;
    localparam int DATA_W_DEF = 16;
    localparam int ACC_W_DEF  = 40;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_EMIT   = 2'd3
    } state_e;

    // Add two sign-extended values, clamping to the signed range of a w-bit accumulator.
    function automatic logic signed [127:0] sat_add(input logic signed [127:0] x,
                                                    input logic signed [127:0] y,
                                                    input int unsigned w);
        logic signed [127:0] sum;
        logic signed [127:0] hi;
        logic signed [127:0] lo;
        sum = x + y;
        hi  = (128'sd1 <<< (w - 1)) - 128'sd1;
        lo  = -(128'sd1 <<< (w - 1));
        if (sum > hi) begin
            return hi;
        end else if (sum < lo) begin
            return lo;
        end
        return sum;
    endfunction

endpackage

// File: rtl/systolic_pe.sv
// One output-stationary MAC cell: registered operand pass-through plus accumulator.
// With SYSTOLIC_SATURATE_EN defined the accumulator clamps instead of wrapping.
module systolic_pe
    import systolic_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ACC_W  = ACC_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear_i,
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    output logic [DATA_W-1:0] a_o,
    output logic [DATA_W-1:0] b_o,
    output logic [ACC_W-1:0]  acc_o
);

    logic signed [2*DATA_W-1:0] prod;
    logic signed [ACC_W-1:0]    prod_ext;
    logic signed [ACC_W-1:0]    base;
    logic signed [ACC_W-1:0]    acc_d;
    logic signed [ACC_W-1:0]    acc_q;
    logic [DATA_W-1:0]          a_q;
    logic [DATA_W-1:0]          b_q;

    // clear_i restarts the sum with this cycle's product rather than zero.
    always_comb begin
        prod     = $signed(a_i) * $signed(b_i);
        prod_ext = ACC_W'(prod);
        base     = clear_i ? '0 : acc_q;
`ifdef SYSTOLIC_SATURATE_EN
        acc_d    = ACC_W'(sat_add(128'(base), 128'(prod_ext), ACC_W));
`else
        acc_d    = base + prod_ext;
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            a_q   <= '0;
            b_q   <= '0;
            acc_q <= '0;
        end else begin
            a_q   <= a_i;
            b_q   <= b_i;
            acc_q <= acc_d;
        end
    end

    assign a_o   = a_q;
    assign b_o   = b_q;
    assign acc_o = acc_q;

endmodule

// File: rtl/systolic_mm_tile.sv
// Output-stationary NxN systolic matrix-multiply tile with skewed operand feed and row-wise drain.
// Accumulator overflow saturates when SYSTOLIC_SATURATE_EN is defined, otherwise wraps.
module systolic_mm_tile
    import systolic_pkg::*;
#(
    parameter int N      = N_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int ACC_W  = ACC_W_DEF
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   in_last,
    input  logic [N*DATA_W-1:0]    a,
    input  logic [N*DATA_W-1:0]    b,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [N*ACC_W-1:0]     out_row,
    output logic [$clog2(N)-1:0]   out_row_idx,
    output logic                   busy,
    output logic [1:0]             dbg_state
);

    localparam int IDX_W = $clog2(N);
    localparam int CNT_W = $clog2(2 * N);
    localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(2 * N - 1);

    // Handshakes: a beat moves when in_valid && in_ready, a row when out_valid && out_ready;
    // in_ready and out_valid depend only on the state register.
    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              accept;
    logic              clear;

    assign in_ready  = (state_q == ST_IDLE) || (state_q == ST_STREAM);
    assign out_valid = (state_q == ST_EMIT);
    assign busy      = (state_q != ST_IDLE);
    assign dbg_state = state_q;
    assign accept    = in_valid && in_ready;
    assign clear     = accept && (state_q == ST_IDLE);

    logic [DATA_W-1:0] a_gated [N];
    logic [DATA_W-1:0] b_gated [N];
    logic [DATA_W-1:0] a_edge  [N];
    logic [DATA_W-1:0] b_edge  [N];

    // Bubbles and ignored beats feed zeros so they never disturb the sums.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            a_gated[i] = accept ? a[i*DATA_W +: DATA_W] : '0;
            b_gated[i] = accept ? b[i*DATA_W +: DATA_W] : '0;
        end
    end

    for (genvar i = 0; i < N; i++) begin : g_skew
        if (i == 0) begin : g_direct
            assign a_edge[i] = a_gated[i];
            assign b_edge[i] = b_gated[i];
        end else begin : g_delay
            logic [DATA_W-1:0] a_dl_q [i];
            logic [DATA_W-1:0] b_dl_q [i];
            always_ff @(posedge clk) begin
                if (reset) begin
                    for (int d = 0; d < i; d++) begin
                        a_dl_q[d] <= '0;
                        b_dl_q[d] <= '0;
                    end
                end else begin
                    a_dl_q[0] <= a_gated[i];
                    b_dl_q[0] <= b_gated[i];
                    for (int d = 1; d < i; d++) begin
                        a_dl_q[d] <= a_dl_q[d-1];
                        b_dl_q[d] <= b_dl_q[d-1];
                    end
                end
            end
            assign a_edge[i] = a_dl_q[i-1];
            assign b_edge[i] = b_dl_q[i-1];
        end
    end

    logic [DATA_W-1:0] a_pass [N][N];
    logic [DATA_W-1:0] b_pass [N][N];
    logic [ACC_W-1:0]  acc    [N][N];

    for (genvar i = 0; i < N; i++) begin : g_row
        for (genvar j = 0; j < N; j++) begin : g_col
            logic [DATA_W-1:0] a_in;
            logic [DATA_W-1:0] b_in;
            if (j == 0) begin : g_a_edge
                assign a_in = a_edge[i];
            end else begin : g_a_pass
                assign a_in = a_pass[i][j-1];
            end
            if (i == 0) begin : g_b_edge
                assign b_in = b_edge[j];
            end else begin : g_b_pass
                assign b_in = b_pass[i-1][j];
            end
            systolic_pe #(.DATA_W(DATA_W), .ACC_W(ACC_W)) u_pe (
                .clk     (clk),
                .reset   (reset),
                .clear_i (clear),
                .a_i     (a_in),
                .b_i     (b_in),
                .a_o     (a_pass[i][j]),
                .b_o     (b_pass[i][j]),
                .acc_o   (acc[i][j])
            );
        end
    end

    // Operands leaving the right/bottom edge of the array have no consumer.
    logic [DATA_W-1:0] unused_pass;
    always_comb begin
        unused_pass = '0;
        for (int i = 0; i < N; i++) begin
            unused_pass = unused_pass ^ a_pass[i][N-1] ^ b_pass[N-1][i];
        end
    end

    always_comb begin
        out_row = '0;
        for (int j = 0; j < N; j++) begin
            out_row[j*ACC_W +: ACC_W] = acc[idx_q][j];
        end
    end
    assign out_row_idx = idx_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    cnt_d   = '0;
                    state_d = in_last ? ST_DRAIN : ST_STREAM;
                end
            end
            ST_STREAM: begin
                if (in_valid && in_last) begin
                    cnt_d   = '0;
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                // Long enough for the last beat to cross the whole skewed array.
                if (cnt_q == DRAIN_LAST) begin
                    idx_d   = '0;
                    state_d = ST_EMIT;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_EMIT: begin
                if (out_ready) begin
                    if (idx_q == IDX_W'(N - 1)) begin
                        idx_d   = '0;
                        state_d = ST_IDLE;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
        end
    end

endmodule
